// File: rtl/sprite_rom_scheduler.sv
// Arbitrates NUM_REQ sprite pixel requesters onto one synchronous ROM port with fixed 2-cycle latency.
// Define SPRITE_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.

module sprite_addr_calc #(
  parameter int ADDR_W    = 15,
  parameter int ROM_DEPTH = 24000
) (
  input  logic [ADDR_W-1:0] base_i,
  input  logic [9:0]        rel_x_i,
  input  logic [9:0]        rel_y_i,
  input  logic [9:0]        width_i,
  output logic [20:0]       sum_o,
  output logic              oob_o
);
  localparam logic [20:0] DEPTH_L = 21'(ROM_DEPTH);
  logic [19:0] prod;

  // Kept at full width so a wrapped address can never alias into bounds.
  assign prod  = 20'(rel_y_i) * 20'(width_i);
  assign sum_o = 21'(prod) + 21'(rel_x_i) + 21'(base_i);
  assign oob_o = (sum_o >= DEPTH_L);
endmodule

module sprite_rom_scheduler #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 15,
  parameter int ROM_DEPTH = 24000,
  parameter int DATA_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_base,
  input  logic [NUM_REQ*10-1:0]     req_rel_x,
  input  logic [NUM_REQ*10-1:0]     req_rel_y,
  input  logic [NUM_REQ*10-1:0]     req_width,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_oob,
  output logic                      busy
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic [NUM_REQ-1:0][20:0] sum_w;
  logic [NUM_REQ-1:0]       oob_w;
  logic [IDX_W-1:0]         start_w, gnt_idx;
  logic                     gnt_any;
  logic [20:0]              sel_sum;
  logic                     sel_oob;
  int                       rr_idx;

  // vld_pipe_q[1]: ROM read in flight, vld_pipe_q[2]: response on the outputs
  logic [2:1]               vld_pipe_q;
  logic [IDX_W-1:0]         tag1_q;
  logic                     oob1_q;
  logic                     rom_en_q;
  logic [ADDR_W-1:0]        rom_addr_q;
  logic [NUM_REQ-1:0]       rsp_valid_q;
  logic                     rsp_oob_q;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      sprite_addr_calc #(.ADDR_W(ADDR_W), .ROM_DEPTH(ROM_DEPTH)) u_calc (
        .base_i  (req_base[i*ADDR_W +: ADDR_W]),
        .rel_x_i (req_rel_x[i*10 +: 10]),
        .rel_y_i (req_rel_y[i*10 +: 10]),
        .width_i (req_width[i*10 +: 10]),
        .sum_o   (sum_w[i]),
        .oob_o   (oob_w[i])
      );
    end
  endgenerate

`ifdef SPRITE_SCHED_FIXED_PRIO_EN
  assign start_w = '0;
`else
  logic [IDX_W-1:0] ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ptr_q <= '0;
    else if (gnt_any) ptr_q <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
  end

  assign start_w = ptr_q;
`endif

  always_comb begin
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    rr_idx    = 0;
    req_ready = '0;
    if (state_q == RUN) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        rr_idx = (int'(start_w) + k) % NUM_REQ;
        if (!gnt_any && req_valid[IDX_W'(rr_idx)]) begin
          gnt_any = 1'b1;
          gnt_idx = IDX_W'(rr_idx);
        end
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  assign sel_sum = sum_w[gnt_idx];
  assign sel_oob = oob_w[gnt_idx];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN:   if (enable) state_d = RUN;
               else if (vld_pipe_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      vld_pipe_q  <= '0;
      tag1_q      <= '0;
      oob1_q      <= 1'b0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      rsp_valid_q <= '0;
      rsp_oob_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      vld_pipe_q <= {vld_pipe_q[1], gnt_any};
      tag1_q     <= gnt_idx;
      oob1_q     <= gnt_any & sel_oob;
      rom_en_q   <= gnt_any & ~sel_oob;
      // An out-of-bounds slot leaves the address bus untouched.
      if (gnt_any && !sel_oob) rom_addr_q <= sel_sum[ADDR_W-1:0];
      rsp_valid_q <= vld_pipe_q[1] ? (NUM_REQ'(1) << tag1_q) : '0;
      rsp_oob_q   <= vld_pipe_q[1] & oob1_q;
    end
  end

  // ROM data arrives in the strobe cycle itself, so it is gated rather than re-registered.
  assign rsp_data  = (|rsp_valid_q && !rsp_oob_q) ? rom_data : '0;
  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_oob   = rsp_oob_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_sprite_rom_scheduler.sv
// Self-checking bench for sprite_rom_scheduler: directed scenarios plus randomized traffic vs a transaction model.
module tb_sprite_rom_scheduler;
  localparam int NUM_REQ   = 2;
  localparam int ADDR_W    = 15;
  localparam int ROM_DEPTH = 24000;
  localparam int DATA_W    = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      enable;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_base;
  logic [NUM_REQ*10-1:0]     req_rel_x, req_rel_y, req_width;
  logic                      rom_en;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data = '0;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_oob;
  logic                      busy;

  int n_chk  = 0;
  int n_fail = 0;

  sprite_rom_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .ROM_DEPTH(ROM_DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_rel_x(req_rel_x), .req_rel_y(req_rel_y), .req_width(req_width),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_oob(rsp_oob), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_f(input int a);
    logic [31:0] t;
    t = 32'(a) * 32'd37 + 32'd11;
    return t[15:0] ^ 16'hA5C3;
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= rom_f(int'(rom_addr));

  // Transaction-level model: a request accepted at one edge shows its ROM strobe
  // one cycle later and its response two cycles later.
  int m_state;            // 0 idle, 1 running, 2 draining
  int m_ptr;
  bit m1_v, m1_oob, m2_v, m2_oob;
  int m1_tag, m1_addr, m2_tag, m2_addr, m_rom_addr;
  int g_now;
  logic [NUM_REQ-1:0] e_ready, e_rsp_valid;
  logic               e_rom_en, e_rsp_oob, e_busy;
  logic [ADDR_W-1:0]  e_rom_addr;
  logic [DATA_W-1:0]  e_rsp_data;

  function automatic int req_sum(input int i);
    return int'(req_base[i*ADDR_W +: ADDR_W]) + int'(req_rel_y[i*10 +: 10]) * int'(req_width[i*10 +: 10])
         + int'(req_rel_x[i*10 +: 10]);
  endfunction

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m1_v = 0; m2_v = 0; m1_oob = 0; m2_oob = 0;
    m1_tag = 0; m2_tag = 0; m1_addr = 0; m2_addr = 0; m_rom_addr = 0;
  endtask

  task automatic expect_now();
    int start;
    #1;
    g_now = -1;
`ifdef SPRITE_SCHED_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    if (m_state == 1)
      for (int k = 0; k < NUM_REQ; k++)
        if (g_now < 0 && req_valid[(start + k) % NUM_REQ]) g_now = (start + k) % NUM_REQ;
    e_ready     = (g_now >= 0) ? NUM_REQ'(1) << g_now : '0;
    e_rom_en    = m1_v && !m1_oob;
    e_rom_addr  = ADDR_W'(m_rom_addr);
    e_rsp_valid = m2_v ? NUM_REQ'(1) << m2_tag : '0;
    e_rsp_oob   = m2_v && m2_oob;
    e_rsp_data  = (m2_v && !m2_oob) ? rom_f(m2_addr) : '0;
    e_busy      = (m_state != 0);
  endtask

  task automatic advance();
    int nxt, s;
    bit empty;
    empty = !m1_v && !m2_v;
    nxt = m_state;
    case (m_state)
      0: if (enable) nxt = 1;
      1: if (!enable) nxt = 2;
      default: if (enable) nxt = 1; else if (empty) nxt = 0;
    endcase
    m2_v = m1_v; m2_oob = m1_oob; m2_tag = m1_tag; m2_addr = m1_addr;
    if (g_now >= 0) begin
      s = req_sum(g_now);
      m1_v = 1; m1_tag = g_now; m1_oob = (s >= ROM_DEPTH); m1_addr = s % 32768;
      if (!m1_oob) m_rom_addr = m1_addr;
      m_ptr = (g_now + 1) % NUM_REQ;
    end else begin
      m1_v = 0; m1_oob = 0;
    end
    @(posedge clk);
    m_state = nxt;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input int base, input int x, input int y, input int w);
    req_base[i*ADDR_W +: ADDR_W] = ADDR_W'(base);
    req_rel_x[i*10 +: 10] = 10'(x);
    req_rel_y[i*10 +: 10] = 10'(y);
    req_width[i*10 +: 10] = 10'(w);
  endtask

  task automatic wait_run();
    enable = 1'b1; req_valid = '0;
    for (int c = 0; c < 8 && m_state != 1; c++) begin expect_now(); advance(); end
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0; req_valid = '0;
    req_base = '0; req_rel_x = '0; req_rel_y = '0; req_width = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_chk++; if (req_ready !== '0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    n_chk++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL rst_rom_en: got %b want 0", rom_en); end
    n_chk++; if (rom_addr !== '0) begin n_fail++; $display("FAIL rst_rom_addr: got %0d want 0", rom_addr); end
    n_chk++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_chk++; if (rsp_data !== '0) begin n_fail++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
    n_chk++; if (rsp_oob !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_oob: got %b want 0", rsp_oob); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst = 1'b1;
  endtask

  task automatic test_single();
    enable = 1'b1; req_valid = '0;
    expect_now();
    n_chk++; if (req_ready !== '0) begin n_fail++; $display("FAIL single_idle_ready: got %b want 00", req_ready); end
    advance();
    set_req(0, 0, 5, 2, 100); req_valid = 2'b01;
    expect_now();
    n_chk++; if (req_ready !== 2'b01 || e_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", req_ready); end
    advance();
    req_valid = '0;
    expect_now();
    n_chk++; if (rom_en !== 1'b1) begin n_fail++; $display("FAIL single_rom_en: got %b want 1", rom_en); end
    n_chk++; if (rom_addr !== 15'd205) begin n_fail++; $display("FAIL single_rom_addr: got %0d want 205", rom_addr); end
    advance();
    expect_now();
    n_chk++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 01", rsp_valid); end
    n_chk++; if (rsp_data !== rom_f(205)) begin n_fail++; $display("FAIL single_rsp_data: got %h want %h", rsp_data, rom_f(205)); end
    n_chk++; if (rsp_oob !== 1'b0) begin n_fail++; $display("FAIL single_rsp_oob: got %b want 0", rsp_oob); end
    advance();
  endtask

  task automatic test_round_robin();
    int g[6];
    wait_run();
    set_req(0, 1000, 3, 4, 50); set_req(1, 5000, 7, 9, 60);
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 6) ? 2'b11 : 2'b00;
      expect_now();
      if (c < 6) g[c] = g_now;
      n_chk++; if (req_ready !== e_ready) begin n_fail++; $display("FAIL rr_ready c%0d: got %b want %b", c, req_ready, e_ready); end
      n_chk++; if (rsp_valid !== e_rsp_valid || rsp_data !== e_rsp_data) begin
        n_fail++; $display("FAIL rr_rsp c%0d: got %b/%h want %b/%h", c, rsp_valid, rsp_data, e_rsp_valid, e_rsp_data); end
      advance();
    end
    for (int c = 1; c < 6; c++) begin
`ifdef SPRITE_SCHED_FIXED_PRIO_EN
      n_chk++; if (g[c] != 0) begin n_fail++; $display("FAIL fixed_prio_grant c%0d: got %0d want 0", c, g[c]); end
`else
      n_chk++; if (g[c] == g[c-1]) begin n_fail++; $display("FAIL rr_alternate c%0d: got %0d want %0d", c, g[c], 1 - g[c-1]); end
`endif
    end
  endtask

  task automatic test_oob();
    int bases[2] = '{23900, 23899};
    for (int t = 0; t < 2; t++) begin
      wait_run();
      set_req(1, bases[t], 0, 1, 100); req_valid = 2'b10;
      expect_now();
      n_chk++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL oob_ready t%0d: got %b want 10", t, req_ready); end
      advance();
      req_valid = '0;
      expect_now();
      n_chk++; if (rom_en !== (t == 1)) begin n_fail++; $display("FAIL oob_rom_en t%0d: got %b want %0d", t, rom_en, t); end
      if (t == 1) begin
        n_chk++; if (rom_addr !== 15'd23999) begin n_fail++; $display("FAIL oob_edge_addr: got %0d want 23999", rom_addr); end
      end
      advance();
      expect_now();
      n_chk++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL oob_rsp_valid t%0d: got %b want 10", t, rsp_valid); end
      n_chk++; if (rsp_oob !== (t == 0)) begin n_fail++; $display("FAIL oob_flag t%0d: got %b want %0d", t, rsp_oob, t == 0); end
      n_chk++; if (rsp_data !== ((t == 0) ? 16'h0 : rom_f(23999))) begin
        n_fail++; $display("FAIL oob_rsp_data t%0d: got %h", t, rsp_data); end
      advance();
    end
  endtask

  task automatic test_drain();
    int c;
    wait_run();
    set_req(0, 100, 1, 1, 1); req_valid = 2'b01; enable = 1'b0;
    expect_now();
    n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL drain_accept: got %b want 01", req_ready); end
    advance();
    expect_now();
    n_chk++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL drain_ready_off: got %b want 00", req_ready); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_busy: got %b want 1", busy); end
    advance();
    req_valid = '0;
    expect_now();
    n_chk++; if (rsp_valid !== 2'b01 || rsp_data !== rom_f(102)) begin
      n_fail++; $display("FAIL drain_rsp: got %b/%h want 01/%h", rsp_valid, rsp_data, rom_f(102)); end
    for (c = 0; c < 6; c++) begin
      n_chk++; if (busy !== e_busy) begin n_fail++; $display("FAIL drain_busy_seq c%0d: got %b want %b", c, busy, e_busy); end
      if (!busy) break;
      advance();
      expect_now();
    end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_idle_timeout: busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    wait_run();
    set_req(0, 10, 1, 1, 10); req_valid = 2'b01;
    expect_now();
    advance();
    rst = 1'b0; enable = 1'b0; req_valid = '0;
    model_reset();
    #1;
    n_chk++; if ({rom_en, rsp_valid, rsp_oob, busy, req_ready} !== '0 || rom_addr !== '0 || rsp_data !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: rom_en %b rom_addr %0d rsp_valid %b busy %b want all 0", rom_en, rom_addr, rsp_valid, busy); end
    repeat (2) begin
      @(negedge clk);
      n_chk++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL midrst_no_rsp: got %b want 00", rsp_valid); end
    end
    rst = 1'b1; enable = 1'b1;
    set_req(1, 20, 2, 2, 10); req_valid = 2'b11;
    expect_now();
    advance();
    expect_now();
    n_chk++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL midrst_first_grant: got %b want 01", req_ready); end
    advance();
    req_valid = '0;
  endtask

  task automatic test_no_trunc();
    int bases[2] = '{0, 2047};
    wait_run();
    for (int t = 0; t < 4; t++) begin
      if (t < 2) begin set_req(0, bases[t], 0, 1023, 1023); req_valid = 2'b01; end
      else req_valid = '0;
      expect_now();
      if (t >= 1 && t <= 2) begin
        n_chk++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL trunc_rom_en t%0d: got %b want 0", t, rom_en); end
      end
      if (t >= 2) begin
        n_chk++; if (rsp_valid !== 2'b01 || rsp_oob !== 1'b1 || rsp_data !== '0) begin
          n_fail++; $display("FAIL trunc_oob t%0d: got %b/%b/%h want 01/1/0", t, rsp_valid, rsp_oob, rsp_data); end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      enable    = ($urandom_range(0, 15) != 0);
      req_valid = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, $urandom_range(0, 20000), $urandom_range(0, 1023), $urandom_range(0, 50), $urandom_range(0, 80));
      expect_now();
      n_chk++; if (req_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, e_ready); end
      n_chk++; if (rom_en !== e_rom_en) begin n_fail++; $display("FAIL rnd_rom_en c%0d: got %b want %b", c, rom_en, e_rom_en); end
      n_chk++; if (rom_addr !== e_rom_addr) begin n_fail++; $display("FAIL rnd_rom_addr c%0d: got %0d want %0d", c, rom_addr, e_rom_addr); end
      n_chk++; if (rsp_valid !== e_rsp_valid) begin n_fail++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", c, rsp_valid, e_rsp_valid); end
      n_chk++; if (rsp_data !== e_rsp_data) begin n_fail++; $display("FAIL rnd_rsp_data c%0d: got %h want %h", c, rsp_data, e_rsp_data); end
      n_chk++; if (rsp_oob !== e_rsp_oob) begin n_fail++; $display("FAIL rnd_rsp_oob c%0d: got %b want %b", c, rsp_oob, e_rsp_oob); end
      n_chk++; if (busy !== e_busy) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, e_busy); end
      advance();
    end
    req_valid = '0; enable = 1'b0;
    repeat (4) begin expect_now(); advance(); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_oob();
    test_drain();
    test_reset_mid();
    test_no_trunc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_rom_scheduler.md
Name: sprite_rom_scheduler

Overview:
Shares one single-port synchronous sprite ROM among NUM_REQ pixel requesters, such as the player 1 and player 2 sprite layers. Each cycle it grants at most one request and computes the ROM address base + rel_y*width + rel_x. It issues the read to the external ROM and returns the data tagged to the winning requester. An enable-driven RUN/DRAIN state machine stops the pipeline cleanly at blanking.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_W, 15, ROM address width
ROM_DEPTH, 24000, valid ROM entries; addresses >= ROM_DEPTH are out of bounds
DATA_W, 16, pixel data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
enable  in  1  high: scheduler may accept requests
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid&ready at clk edge
req_base  in  NUM_REQ*ADDR_W  sprite base address in ROM, requester i at [i*ADDR_W +: ADDR_W]
req_rel_x  in  NUM_REQ*10  pixel x relative to sprite origin
req_rel_y  in  NUM_REQ*10  pixel y relative to sprite origin
req_width  in  NUM_REQ*10  sprite width in pixels
rom_en  out  1  ROM read strobe
rom_addr  out  ADDR_W  ROM read address
rom_data  in  DATA_W  ROM output; valid the cycle after rom_en
rsp_valid  out  NUM_REQ  one-hot response strobe, one cycle
rsp_data  out  DATA_W  returned pixel
rsp_oob  out  1  response was out of bounds (rsp_data forced 0)
busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset (rst=0, async) clears all outputs: req_ready=0, rom_en=0, rom_addr=0, rsp_valid=0, rsp_data=0, rsp_oob=0, busy=0. FSM goes to IDLE; the round-robin pointer goes to 0. Reset mid-transaction discards in-flight reads with no response.
- FSM states:
  - IDLE: enable=1 -> RUN.
  - RUN: enable=0 -> DRAIN.
  - DRAIN: when both pipeline stages are empty -> IDLE. If enable=1 while in DRAIN, go to RUN directly.
- req_ready is combinational from req_valid, the FSM state and the arbiter pointer. It is nonzero only in RUN and is always zero or one-hot. It never asserts for a requester whose req_valid=0.
- Address math: full-precision product rel_y*width (20 bits), plus rel_x and base, evaluated in 21 bits with no truncation before the compare. oob = (sum >= ROM_DEPTH).
- Stage 1, the clock edge where a grant is accepted (T):
  - Registers the tag (requester index) and the oob flag.
  - rom_en is driven to !oob. rom_addr takes sum[ADDR_W-1:0] when in bounds and holds its previous value when oob.
- Stage 2 (T+1 edge): rsp_valid[tag]=1. rsp_data=rom_data when in bounds, 0 when oob; rsp_oob=oob. Responses are therefore visible in cycle T+2.
- Latency is fixed at 2 cycles from accept to response, with throughput of 1 accept per cycle. There is no response backpressure; consumers must take rsp_* in the strobe cycle.
- An out-of-bounds request still occupies its pipeline slot and produces a response, so ordering and count are preserved.
- Stage registers clear their valid bit when no grant occurs.
- busy = (state != IDLE).
- Arbitration is round-robin by default: the search starts at pointer p, p+1, ... mod NUM_REQ. After a grant to i, p becomes (i+1) mod NUM_REQ. With no grant, p is unchanged.

Optional Feature:
Macro SPRITE_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer register is removed.
- Undefined: round-robin as described above.
- Latency, response tagging and all other behaviour are identical in both builds.

Test Plan:
1. Reset release, enable=1, req 0 only with base=0, rel_x=5, rel_y=2, width=100 -> rom_en=1 and rom_addr=205 one cycle after accept; rsp_valid=01 with rsp_data=ROM[205] two cycles after accept.
2. Both requesters valid continuously for 6 cycles (round-robin build) -> grants alternate 0,1,0,1,0,1 and responses follow in the same order. Fixed-priority build: all 6 grants go to 0.
3. req 1 with base=23900, rel_y=1, width=100, rel_x=0 (sum 24000) -> rom_en stays 0; rsp_valid=10, rsp_oob=1, rsp_data=0 at accept+2.
4. Drop enable in the same cycle as an accept -> that request still responds at +2. req_ready=0 from the next cycle. busy falls after the pipeline empties (DRAIN -> IDLE).
5. Assert rst low one cycle after an accept -> all outputs are 0 immediately and no rsp_valid appears. After release with enable=1, the first grant goes to requester 0.
6. Request with rel_y=1023, width=1023, base=0 -> no product truncation occurs, oob=1, and rsp_oob is asserted.
